// File: rtl/tdm_demux_8_if.sv
// Bus between the 8:1 serial channel, the tdm_demux_8 receiver and its parallel consumer.
// TDM_PARITY_EN widens se to 4 bits for the 9-slot parity frame.
interface tdm_demux_8_if;
`ifdef TDM_PARITY_EN
  localparam int SE_W = 4;
`else
  localparam int SE_W = 3;
`endif

  // Handshake: a bit transfers on every rising edge where din_vld=1 (sync qualifies it as
  // slot 0). There is no ready. The consumer takes out on every cycle where out_vld=1.
  logic            din;
  logic            din_vld;
  logic            sync;
  logic            err_clr;
  logic [7:0]      out;
  logic            out_vld;
  logic [SE_W-1:0] se;
  logic            err;
  logic [1:0]      dbg_state;

  modport master (
    output din, din_vld, sync, err_clr,
    input  out, out_vld, se, err, dbg_state
  );

  modport slave (
    input  din, din_vld, sync, err_clr,
    output out, out_vld, se, err, dbg_state
  );
endinterface

// File: rtl/tdm_demux_8.sv
// Receive end of the 8:1 TDM serial channel: locks to sync, rebuilds 8-bit words, flags framing faults.
// TDM_PARITY_EN adds a ninth slot that carries even parity over slots 0-7.
module tdm_demux_8 #(
    parameter int IDLE_TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    tdm_demux_8_if.slave bus
);

`ifdef TDM_PARITY_EN
    localparam int SE_W = 4;
    localparam int SH_W = 8;
    localparam logic [SE_W-1:0] LAST_SLOT = 4'd8;
`else
    localparam int SE_W = 3;
    localparam int SH_W = 7;
    localparam logic [SE_W-1:0] LAST_SLOT = 3'd7;
`endif
    localparam logic [7:0] IDLE_LIM = 8'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        COLLECT   = 2'd1,
        WAIT_SYNC = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SE_W-1:0] se_q, se_d;
    logic [SH_W-1:0] shadow_q, shadow_d;
    logic [7:0]      out_q, out_d;
    logic            out_vld_q, out_vld_d;
    logic            err_q, err_d;
    logic            err_set;
    logic [7:0]      idle_q, idle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            se_q      <= '0;
            shadow_q  <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            se_q      <= se_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
            idle_q    <= idle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        se_d      = se_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        err_set   = 1'b0;
        idle_d    = '0;

        unique case (state_q)
            HUNT, WAIT_SYNC: begin
                if (bus.din_vld && bus.sync) begin
                    shadow_d = SH_W'(bus.din);
                    se_d     = SE_W'(1);
                    state_d  = COLLECT;
                end else if (bus.din_vld && state_q == WAIT_SYNC) begin
                    // A valid bit after a frame must be a new slot 0; anything else is lost lock.
                    err_set = 1'b1;
                    state_d = HUNT;
                end
            end
            COLLECT: begin
                if (bus.din_vld) begin
                    if (bus.sync) begin
                        // Premature sync: drop the partial frame and restart on this bit.
                        err_set  = 1'b1;
                        shadow_d = SH_W'(bus.din);
                        se_d     = SE_W'(1);
                    end else if (se_q == LAST_SLOT) begin
                        se_d    = '0;
                        state_d = WAIT_SYNC;
`ifdef TDM_PARITY_EN
                        if (^{shadow_q, bus.din} == 1'b0) begin
                            out_d     = shadow_q;
                            out_vld_d = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
`else
                        out_d     = {bus.din, shadow_q};
                        out_vld_d = 1'b1;
`endif
                    end else begin
                        shadow_d[se_q[2:0]] = bus.din;
                        se_d                = se_q + SE_W'(1);
                    end
                end else if (idle_q + 8'd1 == IDLE_LIM) begin
                    err_set = 1'b1;
                    se_d    = '0;
                    state_d = HUNT;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            default: begin
                se_d    = '0;
                state_d = HUNT;
            end
        endcase

        // A new fault outranks a same-cycle clear.
        err_d = err_set | (err_q & ~bus.err_clr);
    end

    always_comb begin
        bus.out       = out_q;
        bus.out_vld   = out_vld_q;
        bus.se        = se_q;
        bus.err       = err_q;
        bus.dbg_state = state_q;
    end

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: scoreboard of expected words plus direct flag/state checks.
// Build with TDM_PARITY_EN defined to exercise the 9-slot parity frame.
module tb_tdm_demux_8;

`ifdef TDM_PARITY_EN
  localparam int SE_W = 4;
`else
  localparam int SE_W = 3;
`endif
  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  tdm_demux_8_if bus();

  tdm_demux_8 #(.IDLE_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard: every out_vld pulse must match the oldest pushed word.
  always @(posedge clk) begin
    #1;
    if (bus.out_vld === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_out_vld", 32'(bus.out), 32'hdead);
      else check("sb_out", 32'(bus.out), 32'(exp_q.pop_front()));
    end
  end

  task automatic drive_bit(input logic v, input logic s, input logic d, input logic clr);
    bus.din_vld = v;
    bus.sync    = s;
    bus.din     = d;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
    bus.sync    = 1'b0;
    bus.din     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] word, input int nbits);
    for (int k = 0; k < nbits; k++) drive_bit(1'b1, k == 0, word[k], 1'b0);
  endtask

  // gap_mask bit k inserts a 3-cycle din_vld gap after slot k.
  task automatic send_frame(input logic [7:0] word, input logic [7:0] gap_mask,
                            input logic flip_par, input logic push);
    if (push) exp_q.push_back(word);
    for (int k = 0; k < 8; k++) begin
      drive_bit(1'b1, k == 0, word[k], 1'b0);
      if (gap_mask[k] && k < 7) idle(3);
    end
`ifdef TDM_PARITY_EN
    drive_bit(1'b1, 1'b0, (^word) ^ flip_par, 1'b0);
`else
    if (flip_par) $display("note: parity flip ignored without parity slot");
`endif
  endtask

  initial begin
    bus.din = 1'b0; bus.din_vld = 1'b0; bus.sync = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(bus.out), 0);
    check("rst_out_vld", 32'(bus.out_vld), 0);
    check("rst_se", 32'(bus.se), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_HUNT));
    rst = 1'b0;
    idle(2);

    // Noise in HUNT is discarded silently
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    check("hunt_noise_err", 32'(bus.err), 0);

    // Single frame 0xA5
    send_frame(8'hA5, 8'h00, 1'b0, 1'b1);
    check("a5_out", 32'(bus.out), 32'h a5);
    check("a5_vld", 32'(bus.out_vld), 1);
    check("a5_se", 32'(bus.se), 0);
    check("a5_err", 32'(bus.err), 0);
    check("a5_state", 32'(bus.dbg_state), 32'(ST_WAIT));
    idle(1);
    check("a5_vld_one_cycle", 32'(bus.out_vld), 0);
    check("a5_hold", 32'(bus.out), 32'h a5);

    // Back-to-back frames, gaps inside the second
    send_frame(8'h3C, 8'h00, 1'b0, 1'b1);
    check("3c_out", 32'(bus.out), 32'h3c);
    send_frame(8'hC3, 8'b0010_0100, 1'b0, 1'b1);
    check("c3_out", 32'(bus.out), 32'hc3);
    check("c3_err", 32'(bus.err), 0);

    // Premature sync at slot 4, then clean 0xFF
    send_partial(8'h00, 4);
    check("pre_se", 32'(bus.se), 4);
    send_frame(8'hFF, 8'h00, 1'b0, 1'b1);
    check("pre_err", 32'(bus.err), 1);
    check("pre_out", 32'(bus.out), 32'hff);

    // Idle timeout after slot 2
    drive_bit(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_err", 32'(bus.err), 0);
    send_partial(8'h07, 3);
    idle(15);
    check("to_pre_state", 32'(bus.dbg_state), 32'(ST_COLLECT));
    check("to_pre_err", 32'(bus.err), 0);
    idle(1);
    check("to_err", 32'(bus.err), 1);
    check("to_se", 32'(bus.se), 0);
    check("to_state", 32'(bus.dbg_state), 32'(ST_HUNT));
    drive_bit(1'b0, 1'b0, 1'b0, 1'b1);
    check("to_clr", 32'(bus.err), 0);
    send_frame(8'h01, 8'h00, 1'b0, 1'b1);
    check("01_out", 32'(bus.out), 32'h01);
    check("01_err", 32'(bus.err), 0);

    // Non-sync valid bit in WAIT_SYNC
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    check("ws_err", 32'(bus.err), 1);
    check("ws_out", 32'(bus.out), 32'h01);
    check("ws_state", 32'(bus.dbg_state), 32'(ST_HUNT));
    drive_bit(1'b0, 1'b0, 1'b0, 1'b1);
    check("ws_clr", 32'(bus.err), 0);
    send_frame(8'h96, 8'h00, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b1);
    check("set_beats_clr", 32'(bus.err), 1);
    check("96_out", 32'(bus.out), 32'h96);

    // Asynchronous reset at slot 5
    send_partial(8'h5A, 5);
    #1 rst = 1'b1;
    #1;
    check("arst_out", 32'(bus.out), 0);
    check("arst_vld", 32'(bus.out_vld), 0);
    check("arst_se", 32'(bus.se), 0);
    check("arst_err", 32'(bus.err), 0);
    check("arst_state", 32'(bus.dbg_state), 32'(ST_HUNT));
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(8'h5A, 8'h00, 1'b0, 1'b1);
    check("5a_out", 32'(bus.out), 32'h5a);
    check("5a_err", 32'(bus.err), 0);
`ifdef TDM_PARITY_EN
    send_frame(8'h33, 8'h00, 1'b1, 1'b0);
    check("par_err", 32'(bus.err), 1);
    check("par_vld", 32'(bus.out_vld), 0);
    check("par_out", 32'(bus.out), 32'h5a);
`endif

    // Randomised clean frames with random gaps
    for (int i = 0; i < 6; i++) begin
      logic [7:0] w;
      logic [7:0] g;
      w = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 127));
      send_frame(w, g, 1'b0, 1'b1);
      check("rand_out", 32'(bus.out), 32'(w));
    end
    check("rand_err", 32'(bus.err), 0);

    idle(3);
    check("sb_pending", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
Name: tdm_demux_8

Overview:
- Receive end of the 8:1 serial channel. Takes the 1-bit time-division stream built from 8 parallel bits and rebuilds the 8-bit word.
- A 3-bit slot counter, `se`, tracks the current slot. The block locks to frame sync and flags framing faults.
- The block sits downstream of the 8:1 select tree and drives an 8-bit parallel consumer.

Parameters:
- `IDLE_TIMEOUT`, 16: number of consecutive cycles without `din_vld` allowed mid-frame before the partial frame is aborted. Range 1–255. An 8-bit idle counter implements it.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 1: serial data bit.
- `din_vld` input 1: `din` is valid this cycle.
- `sync` input 1: qualifies `din` as slot 0, the first bit of a frame. Meaningful only when `din_vld`=1.
- `err_clr` input 1: clears `err`.
- `out` output 8: last complete word. Slot k maps to `out[k]`.
- `out_vld` output 1: one-cycle pulse; `out` was updated on the previous edge.
- `se` output 3: slot index expected for the next valid bit.
- `err` output 1: sticky framing-error flag.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - `out`=0, `out_vld`=0, `se`=0, `err`=0.
  - State = HUNT; shadow register = 0; idle counter = 0.
- States: HUNT, COLLECT, WAIT_SYNC.
- HUNT:
  - `din_vld`&`sync`: `shadow[0]`<=`din`, `se`<=1, go to COLLECT.
  - `din_vld`&!`sync`: bit discarded, no error.
- COLLECT:
  - `din_vld`&!`sync`: `shadow[se]`<=`din`, `se`<=`se`+1.
  - When `se`==7, on that same edge: `out`<={`din`, `shadow[6:0]`}, `out_vld`<=1 for the next cycle, `se`<=0, go to WAIT_SYNC.
  - `din_vld`&`sync` (premature sync): `err`<=1. The partial frame is dropped and `out` holds. The current bit restarts a frame: `shadow[0]`<=`din`, `se`<=1, stay in COLLECT.
- WAIT_SYNC:
  - `din_vld`&`sync`: start a new frame as in HUNT.
  - `din_vld`&!`sync`: `err`<=1, bit discarded, go to HUNT.
  - Back-to-back frames with no idle gap are legal.
- Idle timeout:
  - The counter increments each COLLECT cycle with `din_vld`=0 and clears on any valid bit.
  - On reaching `IDLE_TIMEOUT`: `err`<=1, `se`<=0, go to HUNT, partial frame dropped.
  - Not applied in HUNT or WAIT_SYNC.
- Latency: `out` updates on the edge sampling slot 7. `out_vld` is high the following cycle only.
- `out` changes only on a complete, error-free frame and holds otherwise. Gaps in `din_vld` inside a frame, below the timeout, are legal.
- `err`:
  - Sticky; cleared by `err_clr`.
  - If a set and `err_clr` occur in the same cycle, the set wins.
  - `err` never blocks reception.
- `se` is the `out` select value in the transmitter's domain. Slot order is 0..7, LSB first.

Optional Feature:
- Macro: `TDM_PARITY_EN`.
- Defined:
  - Frame is 9 slots; slot 8 carries even parity over slots 0–7.
  - `se` widens to 4 bits and counts 0..8.
  - Parity is checked on the slot-8 edge. Match: `out` updated and `out_vld` pulsed. Mismatch: `err`<=1, `out` holds, no `out_vld`.
  - Sync at slot 8 counts as premature sync.
- Undefined: 8-slot frame exactly as above; no parity logic.

Test Plan:
- Frame 0xA5: after reset, send slots 0..7 = 1,0,1,0,0,1,0,1 with `sync` on slot 0 and `din_vld` continuous → `out`=8'hA5 on the slot-7 edge, `out_vld` one cycle, `se` back to 0, `err`=0.
- Back-to-back frames 0x3C then 0xC3 with no gap, plus 3-cycle `din_vld` gaps inside frame 2 → two `out_vld` pulses, `out`=8'h3C then 8'hC3, `err`=0.
- `sync` reasserted at slot 4, then 8 clean bits of 0xFF → `err`=1, no `out_vld` for the aborted frame, `out`=8'hFF after the restarted frame completes.
- Frame stalled after slot 2 for 16 idle cycles (default `IDLE_TIMEOUT`) → `err`=1, `se`=0, state HUNT. Then `err_clr` and a clean 0x01 frame → `err`=0, `out`=8'h01.
- Non-sync valid bit in WAIT_SYNC after a good frame → `err`=1, `out` unchanged. Same cycle: `err_clr` with a new error event → `err` stays 1.
- `rst` pulsed at slot 5 of a frame → all outputs 0 immediately (asynchronous). The next clean frame 0x5A → `out`=8'h5A. With `TDM_PARITY_EN` defined, the parity bit flipped → `err`=1, no `out_vld`.
